ro_freq_counter: RTL and testbench
==================================

Name: ro_freq_counter

Overview:
Downstream measurement stage for an inverter-chain ring oscillator (odd-length chain closed through an upstream enable gate).
- Drives the oscillator enable.
- Synchronises the free-running oscillator output into the system clock domain.
- Counts its rising edges over a fixed window of system clocks.
- Presents the count on a valid/ready handshake to the readout logic.
The resulting count is the delay signature of the chain: a slower chain gives a lower count.

Parameters:
COUNT_W, 16, width of edge count output
WINDOW_CYCLES, 1024, system clocks in the counting window (>=1)
SETTLE_CYCLES, 16, system clocks the oscillator runs before counting starts (>=1)
SYNC_STAGES, 2, synchroniser flops on roOut (>=2)

Ports:
clk  input  1  system clock; all logic is on its rising edge
rstN  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a measurement
roOut  input  1  oscillator output (asynchronous to clk)
roEnable  output  1  oscillator enable to the upstream gate; 1 = oscillate
busy  output  1  high in every state except IDLE
countValid  output  1  edgeCount holds a completed result
countReady  input  1  consumer accepts the result
edgeCount  output  COUNT_W  rising edges counted in the window
overflow  output  1  count saturated during this window

Behaviour:
Reset (rstN low, asynchronous):
- All state clears: state=IDLE, roEnable=0, busy=0, countValid=0, edgeCount=0, overflow=0.
- Synchroniser flops and the edge-detect flop clear to 0; internal counters clear to 0.
- Reset mid-operation aborts immediately. No result is produced.

Clock/reset naming: one clock, clk; reset is asynchronous, active-low, rstN.

FSM states: IDLE, SETTLE, MEASURE, HOLD.
- IDLE: start=1 -> SETTLE. The timer loads SETTLE_CYCLES-1, edgeCount clears to 0, overflow clears to 0. roEnable goes high on the following cycle and stays high through SETTLE and MEASURE.
- SETTLE: the timer decrements. At 0 -> MEASURE with the timer loaded to WINDOW_CYCLES-1. No edges are counted. Edge detection runs, so the first MEASURE cycle sees no spurious edge.
- MEASURE: a rising edge is the synchronised sample being 1 with the previous sample 0. Each rising edge increments edgeCount. The timer decrements. On the cycle the timer is 0, that cycle's edge is still counted, then -> HOLD. The window is exactly WINDOW_CYCLES cycles.
- HOLD: roEnable=0 and countValid=1. edgeCount and overflow are stable. On countValid&countReady -> IDLE with countValid=0 on the next cycle. Results are never dropped: HOLD waits for countReady indefinitely.

Timing:
- start in IDLE at cycle 0 gives countValid=1 at cycle SETTLE_CYCLES+WINDOW_CYCLES+1.
- start outside IDLE is ignored (no queueing).
- start and handshake completion in the same HOLD cycle: the start is ignored.

Arithmetic:
- edgeCount saturates at 2^COUNT_W-1.
- An edge arriving while saturated sets overflow=1, which is held until the next start.

Limits:
- Measurable roOut frequency is below clk/2; faster oscillation aliases.
- No metastability-sensitive logic sits before the last synchroniser stage.

Optional Feature:
Macro: RO_FREQ_COUNTER_MINMAX_EN.

Defined:
- Adds ports minCount (output, COUNT_W), maxCount (output, COUNT_W) and clearStats (input, 1).
- On each entry to HOLD, the completed edgeCount is compared against the stored values: minCount takes the smaller, maxCount the larger.
- The first result after reset or clearStats loads both directly.
- clearStats=1 invalidates the stored values. minCount and maxCount then read 0 until the next result.
- clearStats and an entry to HOLD in the same cycle: the clear wins, and the new result loads on the next entry to HOLD.
- Reset sets both outputs to 0 and invalidates the stored values.

Undefined:
- The ports and registers are absent.
- All other behaviour is identical.

Test Plan:
- Basic window: WINDOW_CYCLES=1024, SETTLE_CYCLES=16; bench toggles roOut every 4 clk (period 8). Pulse start -> countValid=1 exactly 1041 cycles after the start cycle; edgeCount=128; overflow=0; roEnable high cycles 1..1040.
- Backpressure: countReady=0 for 50 cycles in HOLD -> countValid, edgeCount and roEnable=0 stay stable. Raise countReady -> countValid=0 next cycle, busy=0.
- Saturation: COUNT_W=4, roOut toggles every 2 clk -> edgeCount=15, overflow=1. The next start with roOut held at 0 -> edgeCount=0, overflow=0.
- Ignored start and static input: with roOut stuck at 1, pulse start again during MEASURE -> one result only, edgeCount=0.
- Reset mid-MEASURE: assert rstN low during the window -> all outputs 0 immediately. After release, no countValid appears without a new start.
- MINMAX (macro defined): three windows with toggle periods 8, 16 and 4 (window 1024) -> minCount=64, maxCount=256. Pulse clearStats -> both read 0.

Source files
------------

// File: rtl/ro_freq_counter.sv
// ro_freq_counter: drives a ring-oscillator enable, synchronises its output,
// counts rising edges over a fixed window and offers the count on valid/ready.
// Optional min/max result statistics: define RO_FREQ_COUNTER_MINMAX_EN.
module ro_freq_counter #(
   parameter int COUNT_W       = 16,
   parameter int WINDOW_CYCLES = 1024,
   parameter int SETTLE_CYCLES = 16,
   parameter int SYNC_STAGES   = 2
) (
   input  logic               clk,
   input  logic               rstN,
   input  logic               start,
   input  logic               roOut,
   output logic               roEnable,
   output logic               busy,
   output logic               countValid,
   input  logic               countReady,
   output logic [COUNT_W-1:0] edgeCount,
   output logic               overflow
`ifdef RO_FREQ_COUNTER_MINMAX_EN
   ,
   input  logic               clearStats,
   output logic [COUNT_W-1:0] minCount,
   output logic [COUNT_W-1:0] maxCount
`endif
);

   // Timer only ever holds a load value (cycles-1), so TMAX-1 must fit.
   localparam int TMAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] WINDOW_LOAD = TW'(WINDOW_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, HOLD} state_t;

   state_t                 state, state_nxt;
   logic [TW-1:0]          timer;
   logic [SYNC_STAGES-1:0] sync;
   logic                   sample_prev;
   logic                   rise;
   logic                   sat;
   logic                   timer_zero;

   assign rise       = sync[SYNC_STAGES-1] & ~sample_prev;
   assign sat        = &edgeCount;
   assign timer_zero = (timer == '0);

   assign busy       = (state != IDLE);
   assign roEnable   = (state == SETTLE) || (state == MEASURE);
   assign countValid = (state == HOLD);

   // Synchroniser chain plus edge-detect history; runs in every state so the
   // first MEASURE cycle compares against a real previous sample.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         sync        <= '0;
         sample_prev <= 1'b0;
      end else begin
         sync        <= {sync[SYNC_STAGES-2:0], roOut};
         sample_prev <= sync[SYNC_STAGES-1];
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; start outside IDLE is simply not looked at.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)      state_nxt = SETTLE;
         SETTLE:  if (timer_zero) state_nxt = MEASURE;
         MEASURE: if (timer_zero) state_nxt = HOLD;
         HOLD:    if (countReady) state_nxt = IDLE;
         default:                 state_nxt = IDLE;
      endcase
   end

   // Phase timer and saturating edge counter.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         timer     <= '0;
         edgeCount <= '0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  timer     <= SETTLE_LOAD;
                  edgeCount <= '0;
                  overflow  <= 1'b0;
               end
            end
            SETTLE: begin
               timer <= timer_zero ? WINDOW_LOAD : timer - 1'b1;
            end
            MEASURE: begin
               if (!timer_zero) timer <= timer - 1'b1;
               if (rise) begin
                  if (sat) overflow  <= 1'b1;
                  else     edgeCount <= edgeCount + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef RO_FREQ_COUNTER_MINMAX_EN
   logic               stats_vld;
   logic               hold_entry;
   logic [COUNT_W-1:0] count_final;

   // The result that will sit in edgeCount once HOLD is entered.
   assign hold_entry  = (state == MEASURE) && timer_zero;
   assign count_final = (rise && !sat) ? edgeCount + 1'b1 : edgeCount;

   // Min/max tracking; a clear in the same cycle as a result discards it.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         stats_vld <= 1'b0;
         minCount  <= '0;
         maxCount  <= '0;
      end else if (clearStats) begin
         stats_vld <= 1'b0;
         minCount  <= '0;
         maxCount  <= '0;
      end else if (hold_entry) begin
         stats_vld <= 1'b1;
         if (!stats_vld || count_final < minCount) minCount <= count_final;
         if (!stats_vld || count_final > maxCount) maxCount <= count_final;
      end
   end
`endif

endmodule

// File: tb/tb_ro_freq_counter.sv
// tb_ro_freq_counter: scoreboarded bench for ro_freq_counter. Two instances:
// a default-size one and a 4-bit one for saturation. Oscillators are modelled
// as square waves that only run while roEnable is high.
module tb_ro_freq_counter;

   localparam int CW   = 16;
   localparam int WIN  = 1024;
   localparam int SET  = 16;
   localparam int SW   = 4;
   localparam int SWIN = 64;
   localparam int SSET = 4;

   typedef struct {
      int cnt;
      int ovf;
      int sc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstN;
   logic start, ro, ro_en, busy, cv, cr, ovf;
   logic [CW-1:0] cnt;
   logic s_start, s_ro, s_en, s_busy, s_cv, s_cr, s_ovf;
   logic [SW-1:0] s_cnt;
`ifdef RO_FREQ_COUNTER_MINMAX_EN
   logic clr;
   logic [CW-1:0] mn, mx;
   logic [SW-1:0] s_mn, s_mx;
`endif

   ro_freq_counter #(.COUNT_W(CW), .WINDOW_CYCLES(WIN), .SETTLE_CYCLES(SET), .SYNC_STAGES(2)) dut (
      .clk(clk), .rstN(rstN), .start(start), .roOut(ro), .roEnable(ro_en), .busy(busy),
      .countValid(cv), .countReady(cr), .edgeCount(cnt), .overflow(ovf)
`ifdef RO_FREQ_COUNTER_MINMAX_EN
      , .clearStats(clr), .minCount(mn), .maxCount(mx)
`endif
   );

   ro_freq_counter #(.COUNT_W(SW), .WINDOW_CYCLES(SWIN), .SETTLE_CYCLES(SSET), .SYNC_STAGES(3)) dut_s (
      .clk(clk), .rstN(rstN), .start(s_start), .roOut(s_ro), .roEnable(s_en), .busy(s_busy),
      .countValid(s_cv), .countReady(s_cr), .edgeCount(s_cnt), .overflow(s_ovf)
`ifdef RO_FREQ_COUNTER_MINMAX_EN
      , .clearStats(clr), .minCount(s_mn), .maxCount(s_mx)
`endif
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   exp_t q[$];
   exp_t sq[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Oscillator models: half = cycles per level (0 = stuck at 'stuck').
   int  half = 0, s_half = 0;
   bit  stuck = 0, s_stuck = 0;
   initial begin
      int ph = 0;
      ro = 1'b0;
      forever begin
         @(negedge clk);
         if (half == 0) ro = stuck;
         else if (!ro_en) ph = 0;
         else begin
            ph++;
            if (ph >= half) begin ph = 0; ro = ~ro; end
         end
      end
   end
   initial begin
      int ph = 0;
      s_ro = 1'b0;
      forever begin
         @(negedge clk);
         if (s_half == 0) s_ro = s_stuck;
         else if (!s_en) ph = 0;
         else begin
            ph++;
            if (ph >= s_half) begin ph = 0; s_ro = ~s_ro; end
         end
      end
   end

   // Monitors: every new result is checked against the oldest expectation.
   initial begin
      logic cv_d = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rstN && cv && !cv_d) begin
            if (q.size() == 0) chk("spurious_valid", cv, 0);
            else begin
               e = q.pop_front();
               chk("edge_count", cnt, e.cnt);
               chk("overflow", ovf, e.ovf);
               chk("latency", cyc - e.sc, SET + WIN + 1);
            end
         end
         cv_d = cv;
      end
   end
   initial begin
      logic cv_d = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rstN && s_cv && !cv_d) begin
            if (sq.size() == 0) chk("s_spurious_valid", s_cv, 0);
            else begin
               e = sq.pop_front();
               chk("s_edge_count", s_cnt, e.cnt);
               chk("s_overflow", s_ovf, e.ovf);
               chk("s_latency", cyc - e.sc, SSET + SWIN + 1);
            end
         end
         cv_d = s_cv;
      end
   end

   // One measurement on the main instance. Model: a square wave whose period
   // divides the window yields exactly WIN/period rising edges.
   task automatic run_main(input int h, input bit st, input int hold, input bit extra, input bit hs_start);
      exp_t e;
      int   n = 0, en = 0;
      logic [CW-1:0] c0;
      half = h; stuck = st;
      repeat (4) @(negedge clk);
      start = 1'b1;
      e.cnt = (h == 0) ? 0 : WIN / (2 * h);
      e.ovf = 0;
      e.sc  = cyc;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      if (ro_en) en++;
      while (!cv && n < 3000) begin
         @(negedge clk);
         n++;
         start = extra && (n == SET + 20);
         if (ro_en) en++;
      end
      start = 1'b0;
      chk("valid_timeout", cv, 1);
      chk("ro_enable_cycles", en, SET + WIN);
      c0 = cnt;
      repeat (hold) @(negedge clk);
      chk("hold_valid", cv, 1);
      chk("hold_count", cnt, c0);
      chk("hold_ro_enable", ro_en, 0);
      cr = 1'b1;
      start = hs_start;
      @(negedge clk);
      cr = 1'b0;
      start = 1'b0;
      chk("release_valid", cv, 0);
      chk("release_busy", busy, 0);
   endtask

   task automatic run_small(input int h, input bit st);
      exp_t e;
      int   n = 0, edges;
      s_half = h; s_stuck = st;
      repeat (4) @(negedge clk);
      s_start = 1'b1;
      edges = (h == 0) ? 0 : SWIN / (2 * h);
      e.cnt = (edges > (1 << SW) - 1) ? (1 << SW) - 1 : edges;
      e.ovf = (edges > (1 << SW) - 1) ? 1 : 0;
      e.sc  = cyc;
      sq.push_back(e);
      @(negedge clk);
      s_start = 1'b0;
      while (!s_cv && n < 500) begin @(negedge clk); n++; end
      chk("s_valid_timeout", s_cv, 1);
      s_cr = 1'b1;
      @(negedge clk);
      s_cr = 1'b0;
      chk("s_release_valid", s_cv, 0);
   endtask

   initial begin
      int hs[6] = '{0, 2, 4, 8, 16, 32};
      rstN = 1'b0; start = 1'b0; cr = 1'b0; s_start = 1'b0; s_cr = 1'b0;
`ifdef RO_FREQ_COUNTER_MINMAX_EN
      clr = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_valid", cv, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ro_enable", ro_en, 0);
      chk("rst_count", cnt, 0);
      chk("rst_overflow", ovf, 0);
      chk("rst_s_valid", s_cv, 0);
      rstN = 1'b1;

      // basic window with 50 cycles of backpressure, start during handshake
      run_main(4, 0, 50, 0, 1);
      @(negedge clk);
      chk("hs_start_ignored", busy, 0);
      // static high input plus a start pulse during MEASURE
      run_main(0, 1, 3, 1, 0);
      // randomized windows
      for (int i = 0; i < 6; i++)
         run_main(hs[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                  $urandom_range(0, 20), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      // saturation, then a clean window on the 4-bit instance
      run_small(2, 0);
      run_small(0, 0);
      run_small(1 << $urandom_range(1, 3), 0);

      // reset in the middle of the window
      half = 4;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (500) @(negedge clk);
      chk("mid_busy", busy, 1);
      rstN = 1'b0;
      #1;
      chk("mid_rst_valid", cv, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ro_enable", ro_en, 0);
      chk("mid_rst_count", cnt, 0);
      chk("mid_rst_overflow", ovf, 0);
      @(negedge clk);
      rstN = 1'b1;
      repeat (1200) @(negedge clk);
      chk("post_rst_valid", cv, 0);
      chk("post_rst_busy", busy, 0);

`ifdef RO_FREQ_COUNTER_MINMAX_EN
      begin
         int hv[3] = '{4, 8, 2};
         int lo = 1 << 30, hi = 0, c;
         @(negedge clk); clr = 1'b1;
         @(negedge clk); clr = 1'b0;
         for (int i = 0; i < 3; i++) begin
            c = WIN / (2 * hv[i]);
            if (c < lo) lo = c;
            if (c > hi) hi = c;
            run_main(hv[i], 0, 2, 0, 0);
         end
         chk("min_count", mn, lo);
         chk("max_count", mx, hi);
         @(negedge clk); clr = 1'b1;
         @(negedge clk); clr = 1'b0;
         chk("min_cleared", mn, 0);
         chk("max_cleared", mx, 0);
      end
`endif

      repeat (10) @(negedge clk);
      chk("pending_main", q.size(), 0);
      chk("pending_small", sq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
